// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus between the fetch stage and memory.
//   imem_req   : one-cycle fetch request strobe (fetch stage -> memory)
//   imem_addr  : fetch address, qualified by imem_req
//   imem_valid : one-cycle response strobe (memory -> fetch stage)
//   imem_rdata : instruction word, qualified by imem_valid
// Handshake: there is no ready/back-pressure. A request is accepted on the
// rising edge where imem_req=1. The memory answers every accepted request
// with exactly one imem_valid pulse, at least one cycle later. The fetch
// stage never has more than one request in flight.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_valid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single outstanding memory request
// and the IF/ID pipeline register.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   stall             : hold the IF/ID outputs (from hazard logic)
//   PCSrc, PCTarget   : redirect request and target (low two bits ignored)
//   imem              : instruction-memory bus (master side)
//   InstrD, PCD,
//   PCPlus4D, ValidD  : IF/ID register contents
//   fsm_state         : debug view of the FSM (0=ISSUE 1=WAIT 2=HOLD 3=DROP)
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  PCSrc,
  input  logic [DATA_WIDTH-1:0] PCTarget,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic [1:0]            fsm_state
);

  localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(32'h00000013);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  // ISSUE: free to request; WAIT: request in flight;
  // HOLD: response parked while decode is stalled;
  // DROP: request in flight whose response must be thrown away.
  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] pcf, pcf_n;
  logic [DATA_WIDTH-1:0] hold_instr, hold_instr_n;
  logic [DATA_WIDTH-1:0] hold_pc, hold_pc_n;
  logic [DATA_WIDTH-1:0] instr_n, pcd_n, pcp4_n;
  logic                  valid_n;
  logic                  req;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_instr, load_pc;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pcf;
  assign fsm_state      = state;

  always_comb begin
    state_n      = state;
    pcf_n        = pcf;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    instr_n      = InstrD;
    pcd_n        = PCD;
    pcp4_n       = PCPlus4D;
    valid_n      = ValidD;
    load         = 1'b0;
    load_instr   = '0;
    load_pc      = '0;
    req          = (state == ISSUE) && !PCSrc && !stall;

    if (PCSrc) begin
      // Redirect beats stall. Leaving HOLD is what discards the parked word.
      pcf_n   = {PCTarget[DATA_WIDTH-1:2], 2'b00};
      valid_n = 1'b0;
      instr_n = NOP;
      case (state)
        // A request still in flight must be drained before issuing again;
        // if its response is arriving right now it is simply dropped.
        WAIT, DROP: state_n = imem.imem_valid ? ISSUE : DROP;
        default:    state_n = ISSUE;
      endcase
    end else begin
      case (state)
        ISSUE: begin
          if (req) state_n = WAIT;
        end
        WAIT: begin
          if (imem.imem_valid) begin
            if (stall) begin
              hold_instr_n = imem.imem_rdata;
              hold_pc_n    = pcf;
              state_n      = HOLD;
            end else begin
              load       = 1'b1;
              load_instr = imem.imem_rdata;
              load_pc    = pcf;
              state_n    = ISSUE;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            load       = 1'b1;
            load_instr = hold_instr;
            load_pc    = hold_pc;
            state_n    = ISSUE;
          end
        end
        DROP: begin
          if (imem.imem_valid) state_n = ISSUE;
        end
        default: state_n = ISSUE;
      endcase

      if (load) begin
        instr_n = load_instr;
        pcd_n   = load_pc;
        pcp4_n  = load_pc + FOUR;
        valid_n = 1'b1;
        pcf_n   = pcf + FOUR;
      end else if (!stall) begin
        // Nothing to hand to decode this cycle: insert a bubble.
        valid_n = 1'b0;
        instr_n = NOP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ISSUE;
      pcf        <= RESET_PC;
      hold_instr <= NOP;
      hold_pc    <= '0;
      InstrD     <= NOP;
      PCD        <= '0;
      PCPlus4D   <= '0;
      ValidD     <= 1'b0;
    end else begin
      state      <= state_n;
      pcf        <= pcf_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
      InstrD     <= instr_n;
      PCD        <= pcd_n;
      PCPlus4D   <= pcp4_n;
      ValidD     <= valid_n;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning instruction/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  meaning single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  meaning hold IF/ID outputs (from hazard logic).
REQ-006 SHALL have port PCSrc  input  1  meaning take redirect this cycle (branch/jump from control).
REQ-007 SHALL have port PCTarget  input  DATA_WIDTH  meaning redirect address.
REQ-008 SHALL have port imem_req  output  1  meaning one-cycle fetch request strobe.
REQ-009 SHALL have port imem_addr  output  DATA_WIDTH  meaning fetch address, equals PCF.
REQ-010 SHALL have port imem_valid  input  1  meaning response strobe, arrives >=1 cycle after imem_req.
REQ-011 SHALL have port imem_rdata  input  DATA_WIDTH  meaning instruction word, qualified by imem_valid.
REQ-012 SHALL have port InstrD  output  DATA_WIDTH  meaning IF/ID instruction feeding decode (op = InstrD[6:0]).
REQ-013 SHALL have port PCD  output  DATA_WIDTH  meaning PC of InstrD.
REQ-014 SHALL have port PCPlus4D  output  DATA_WIDTH  meaning PCD + 4.
REQ-015 SHALL have port ValidD  output  1  meaning InstrD is a real instruction, not a bubble.

Function
REQ-016 SHALL implement states ISSUE, WAIT, HOLD, DROP with at most one outstanding request.
REQ-017 ISSUE: imem_req = !PCSrc && !stall; imem_addr = PCF; on request -> WAIT; otherwise stay.
REQ-018 WAIT, imem_valid=1, stall=0, PCSrc=0: load IF/ID (InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1), PCF<=PCF+4, -> ISSUE.
REQ-019 WAIT, imem_valid=1, stall=1, PCSrc=0: capture imem_rdata/PCF into one-entry hold buffer, IF/ID unchanged, -> HOLD.
REQ-020 HOLD, stall=0, PCSrc=0: load IF/ID from hold buffer, PCF<=PCF+4, -> ISSUE.
REQ-021 Redirect (PCSrc=1) SHALL override stall: PCF<=PCTarget with bits [1:0] forced to 00; IF/ID flushed (ValidD=0, InstrD=32'h00000013, PCD/PCPlus4D unchanged); hold buffer discarded.
REQ-022 Redirect next state: from ISSUE/HOLD -> ISSUE; from WAIT with imem_valid=1 -> ISSUE (data discarded); from WAIT with imem_valid=0 -> DROP; from DROP -> DROP (PCF updated again).
REQ-023 DROP: imem_req=0; on imem_valid=1 discard data, -> ISSUE.
REQ-024 When stall=0, PCSrc=0 and no instruction is loaded this cycle, IF/ID SHALL become a bubble (ValidD=0, InstrD=NOP).
REQ-025 When stall=1 and PCSrc=0, IF/ID SHALL hold all values.
REQ-026 imem_valid in ISSUE or HOLD SHALL be ignored.
REQ-027 PC arithmetic SHALL be modulo 2^DATA_WIDTH (0xFFFFFFFC + 4 = 0x00000000).
REQ-028 Minimum fetch throughput SHALL be one instruction per 2 cycles with 1-cycle memory latency.

Reset
REQ-029 rst=1 SHALL immediately set state=ISSUE, PCF=RESET_PC, hold buffer empty, ValidD=0, InstrD=32'h00000013, PCD=0, PCPlus4D=0.
REQ-030 Reset mid-operation SHALL abandon any outstanding request; first post-reset imem_req SHALL be on the first edge with rst=0, addr RESET_PC.

Verification
REQ-031 Reset release, memory responds 1 cycle after req with 32'h00500093 -> req addr 0xBFC00000; next cycle InstrD=32'h00500093, PCD=0xBFC00000, PCPlus4D=0xBFC00004, ValidD=1; next req addr 0xBFC00004.
REQ-032 stall=1 held through response 32'h00A00113 -> IF/ID unchanged, state HOLD; stall=0 -> one cycle later InstrD=32'h00A00113, ValidD=1.
REQ-033 PCSrc=1, PCTarget=0xBFC00040 while WAIT, response arrives next cycle -> data discarded, ValidD=0, InstrD=NOP, next req addr 0xBFC00040.
REQ-034 PCSrc=1 with stall=1 and PCTarget=0xBFC00043 -> flush wins, ValidD=0, next req addr 0xBFC00040.
REQ-035 rst pulse during WAIT, stale imem_valid after release -> ignored; ValidD=0 until fresh response for 0xBFC00000.
REQ-036 RESET_PC=0xFFFFFFFC, two fetches -> PCD sequence 0xFFFFFFFC then 0x00000000, PCPlus4D 0x00000000 then 0x00000004.
